// File: rtl/sum_serial_nib_pkg.sv
// Shared types and constants for the nibble-serial multi-word adder.
// Holds the FSM state encoding, the nibble width and a nibble-count helper.
package sum_serial_nib_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of NIB_W-bit nibbles needed to cover a word of the given width.
   function automatic int unsigned nib_count(input int unsigned width);
      return (width + NIB_W - 1) / NIB_W;
   endfunction

endpackage

// File: rtl/sum_serial_nib_nib4.sv
// Purely combinational 4-bit adder core with carry in and carry out.
// It is the only arithmetic element of the serial adder.
module sum_nib4
   import sum_serial_nib_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   localparam int unsigned SUM_W = NIB_W + 1;

   logic [SUM_W-1:0] full_sum;

   assign full_sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
   assign sum      = full_sum[NIB_W-1:0];
   assign cout     = full_sum[NIB_W];

endmodule

// File: rtl/sum_serial_nib.sv
// Multi-word adder that walks one nibble per cycle through a single 4-bit core,
// keeping the carry in a register, with valid/ready handshakes on both sides.
module sum_serial_nib
   import sum_serial_nib_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] a,
   input  logic [NIB_W*NIBBLES-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] sum,
   output logic                     cout,
   output logic                     busy
);

   localparam int unsigned WIDTH = NIB_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;

   logic [NIB_W-1:0]   core_a;
   logic [NIB_W-1:0]   core_b;
   logic [NIB_W-1:0]   core_sum;
   logic               core_cout;

   // Select the operand nibbles addressed by the current index.
   always_comb begin
      core_a = '0;
      core_b = '0;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (IDX_W'(i) == idx_q) begin
            core_a = a_q[i*NIB_W +: NIB_W];
            core_b = b_q[i*NIB_W +: NIB_W];
         end
      end
   end

   sum_nib4 u_core (
      .a    (core_a),
      .b    (core_b),
      .cin  (carry_q),
      .sum  (core_sum),
      .cout (core_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic; the handshake flags are computed from the next state
   // so they can be registered without adding a cycle of latency.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               carry_d    = cin;
               idx_d      = '0;
               sum_d      = '0;
               cout_d     = 1'b0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end

         RUN: begin
            for (int i = 0; i < int'(NIBBLES); i++) begin
               if (IDX_W'(i) == idx_q) begin
                  sum_d[i*NIB_W +: NIB_W] = core_sum;
               end
            end
            carry_d = core_cout;
            if (idx_q == IDX_LAST) begin
               // Index parks at zero so it never exceeds the last nibble.
               idx_d       = '0;
               cout_d      = core_cout;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign busy      = busy_q;

endmodule
